key_debouncer: RTL and testbench

//  Conditions one raw push-button (active-low, asynchronous, bouncing) into clean single-cycle events.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_sync.sv | 24 ++
 rtl/key_debouncer.sv | 171 +++++++++++++++++
 tb/tb_key_debouncer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and pin polarity for the push-button debouncer.
package key_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PDEB = 2'd1,
      S_HELD = 2'd2,
      S_RDEB = 2'd3
   } key_state_t;

   localparam logic KEY_PRESSED = 1'b0;

   function automatic logic key_is_pressed(input logic pin);
      return pin == KEY_PRESSED;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key pin; resets to the released level (1).
module key_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces one active-low push-button into press/release/long-press pulses plus a level.
// Define KEY_AUTOREPEAT_EN to repeat o_press every REPEAT_CYCLES after a long press.
module key_debouncer
   import key_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = 50_000,
   parameter int unsigned LONG_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_level
);

   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

   // Elaboration-time guards on the counter ranges
   if (DEB_CYCLES < 2) begin : g_chk_deb
      $error("key_debouncer: DEB_CYCLES must be >= 2");
   end
   if (LONG_CYCLES <= DEB_CYCLES) begin : g_chk_long
      $error("key_debouncer: LONG_CYCLES must exceed DEB_CYCLES");
   end
   if (REPEAT_CYCLES < 2) begin : g_chk_rep
      $error("key_debouncer: REPEAT_CYCLES must be >= 2");
   end

   logic sync_key;
   logic pk;

   key_state_t        state_q, state_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic              level_q, level_d;

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   key_sync u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_key_n),
      .o_q   (sync_key)
   );

   assign pk = key_is_pressed(sync_key);

   // Next-state, counter and pulse logic
   always_comb begin
      state_d   = state_q;
      deb_d     = deb_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_d     = rep_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pk) begin
               state_d = S_PDEB;
               deb_d   = '0;
            end
         end
         S_PDEB: begin
            if (!pk) begin
               state_d = S_IDLE;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = S_HELD;
               deb_d   = '0;
               hold_d  = '0;
               press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
               rep_d   = '0;
`endif
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         S_HELD: begin
            if (!pk) begin
               state_d = S_RDEB;
               deb_d   = '0;
            end else if (hold_q == HOLD_LAST) begin
               hold_d = HOLD_SAT;
               long_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
               rep_d  = '0;
`endif
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + HOLD_W'(1);
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (rep_q == REP_LAST) begin
               press_d = 1'b1;
               rep_d   = '0;
            end else begin
               rep_d = rep_q + REP_W'(1);
            end
`endif
         end
         S_RDEB: begin
            // A re-press here is release bounce: resume the hold without a new press
            if (pk) begin
               state_d = S_HELD;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d   = S_IDLE;
               deb_d     = '0;
               release_d = 1'b1;
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            deb_d   = '0;
         end
      endcase
      level_d = (state_d == S_HELD) || (state_d == S_RDEB);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         deb_q     <= '0;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         level_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rep_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         deb_q     <= deb_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         level_q   <= level_d;
`ifdef KEY_AUTOREPEAT_EN
         rep_q     <= rep_d;
`endif
      end
   end

   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;
   assign o_level   = level_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEB=4, LONG=20, REPEAT=8.
module tb_key_debouncer;

   logic clk = 1'b0;
   logic rst;
   logic key_n;
   logic press, rel, lng, lvl;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic rst;
      logic key_n;
      logic press;
      logic rel;
      logic lng;
      logic lvl;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   key_debouncer #(
      .DEB_CYCLES    (4),
      .LONG_CYCLES   (20),
      .REPEAT_CYCLES (8)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_key_n   (key_n),
      .o_press   (press),
      .o_release (rel),
      .o_long    (lng),
      .o_level   (lvl)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic ep, input logic er,
                          input logic el, input logic elv);
      chk({tag, ".press"},   press, ep);
      chk({tag, ".release"}, rel,   er);
      chk({tag, ".long"},    lng,   el);
      chk({tag, ".level"},   lvl,   elv);
   endtask

   task automatic add(input logic r, input logic k, input logic p,
                      input logic rl, input logic l, input logic lv);
      vec_t v;
      v.rst = r; v.key_n = k; v.press = p; v.rel = rl; v.lng = l; v.lvl = lv;
      vq.push_back(v);
   endtask

   initial begin
      logic exp_p;
      rst   = 1'b1;
      key_n = 1'b1;

      // Reset, clean press (pulse after edge 7), clean release (pulse after edge 7)
      add(1, 1, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, 1);
      add(0, 1, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         rst   = vq[i].rst;
         key_n = vq[i].key_n;
         tick();
         chk_all($sformatf("vec%0d", i), vq[i].press, vq[i].rel, vq[i].lng, vq[i].lvl);
      end

      // Press bounce: low 2, high 1, low held -> single press after edge 10
      for (int t = 1; t <= 13; t++) begin
         key_n = (t == 3) ? 1'b1 : 1'b0;
         tick();
         chk_all($sformatf("pbounce%0d", t), (t == 10), 1'b0, 1'b0, (t >= 10));
      end

      // Release bounce: high 2 cycles then pressed again -> level stays, no events
      for (int t = 1; t <= 12; t++) begin
         key_n = (t <= 2) ? 1'b1 : 1'b0;
         tick();
         chk_all($sformatf("rbounce%0d", t), 1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Clean release
      for (int t = 1; t <= 8; t++) begin
         key_n = 1'b1;
         tick();
         chk_all($sformatf("rel%0d", t), 1'b0, (t == 7), 1'b0, (t < 7));
      end

      // Long press: o_long 20 after o_press; repeats 8 and 16 after o_long if enabled
      for (int t = 1; t <= 7; t++) begin
         key_n = 1'b0;
         tick();
         chk_all($sformatf("lpress%0d", t), (t == 7), 1'b0, 1'b0, (t == 7));
      end
      for (int i = 1; i <= 40; i++) begin
         tick();
`ifdef KEY_AUTOREPEAT_EN
         exp_p = (i == 28) || (i == 36);
`else
         exp_p = 1'b0;
`endif
         chk_all($sformatf("long%0d", i), exp_p, 1'b0, (i == 20), 1'b1);
      end

      // Reset while held: outputs clear, key re-qualified with a fresh press
      rst = 1'b1;
      tick();
      chk_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         chk_all($sformatf("postrst%0d", t), (t == 7), 1'b0, 1'b0, (t >= 7));
      end

      // Final release back to idle
      for (int t = 1; t <= 8; t++) begin
         key_n = 1'b1;
         tick();
         chk_all($sformatf("frel%0d", t), 1'b0, (t == 7), 1'b0, (t < 7));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
